// File: rtl/kbd_seg_ctrl.sv
// rtl/kbd_seg_ctrl.sv - PS/2 keyboard receiver, make/break decoder and seven-segment display driver
module kbd_seg_ctrl #(
  parameter int CNT_DIGITS  = 4,
  parameter int TIMEOUT_CYC = 50000,
  parameter int SYNC_STAGES = 3
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        ps2_clk,
  input  logic                        ps2_data,
  output logic [8*(4+CNT_DIGITS)-1:0] seg,
  output logic                        key_press,
  output logic                        frame_err
);
  localparam int CW  = 4 * CNT_DIGITS;
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  localparam int SW  = 8 * (4 + CNT_DIGITS);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   ps2_fall, ps2_bit;
  logic [9:0]             shift_q, shift_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [WDW-1:0]         wd_q, wd_d;
  logic                   byte_valid_q, byte_valid_d;
  logic [7:0]             byte_q, byte_d;
  logic                   frame_err_q, frame_err_d;
  logic [10:0]            frame;
  logic                   frame_ok;

  state_t                 state_q, state_d;
  logic                   dec_make, dec_brk, dec_ext, hit;
  logic                   held_q, held_d, ext_q, ext_d;
  logic [7:0]             code_q, code_d, ascii;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   key_press_q, key_press_d;
  logic [SW-1:0]          seg_q, seg_d;

  function automatic logic [7:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 8'hC0;  4'h1: hex7 = 8'hF9;  4'h2: hex7 = 8'hA4;  4'h3: hex7 = 8'hB0;
      4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h92;  4'h6: hex7 = 8'h82;  4'h7: hex7 = 8'hF8;
      4'h8: hex7 = 8'h80;  4'h9: hex7 = 8'h90;  4'hA: hex7 = 8'h88;  4'hB: hex7 = 8'h83;
      4'hC: hex7 = 8'hC6;  4'hD: hex7 = 8'hA1;  4'hE: hex7 = 8'h86;  default: hex7 = 8'h8E;
    endcase
  endfunction

  assign ps2_fall = clk_sync_q[SYNC_STAGES-1] & ~clk_sync_q[SYNC_STAGES-2];
  assign ps2_bit  = data_sync_q[SYNC_STAGES-1];
  // The last bit of a frame is checked as it arrives, so only the previous ten are stored.
  assign frame    = {ps2_bit, shift_q};
  assign frame_ok = ~frame[0] & frame[10] & (^frame[9:1]);

  always_comb begin
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    wd_d         = wd_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (ps2_fall) begin
      shift_d = frame[10:1];
      wd_d    = '0;
      if (bit_cnt_q == 4'd10) begin
        bit_cnt_d    = 4'd0;
        byte_d       = frame[8:1];
        byte_valid_d = frame_ok;
        frame_err_d  = ~frame_ok;
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (wd_q == WDW'(TIMEOUT_CYC - 1)) begin
        bit_cnt_d = 4'd0;
        wd_d      = '0;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end else begin
      wd_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      clk_sync_q   <= '0;
      data_sync_q  <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      wd_q         <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q  <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      wd_q         <= wd_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (byte_valid_q) begin
      case (state_q)
        S_IDLE: begin
          if (byte_q == 8'hF0)      state_d = S_BRK;
          else if (byte_q == 8'hE0) state_d = S_EXT;
        end
        S_EXT:   state_d = (byte_q == 8'hF0) ? S_EXT_BRK : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    dec_make = 1'b0;
    dec_brk  = 1'b0;
    dec_ext  = 1'b0;
    if (byte_valid_q) begin
      case (state_q)
        S_IDLE:  dec_make = (byte_q != 8'hF0) && (byte_q != 8'hE0);
        S_EXT:   begin dec_make = (byte_q != 8'hF0); dec_ext = 1'b1; end
        S_BRK:   dec_brk = 1'b1;
        default: begin dec_brk = 1'b1; dec_ext = 1'b1; end
      endcase
    end
  end

  // A make matching the held key is typematic repeat; anything else is a fresh press.
  assign hit = held_q && ({dec_ext, byte_q} == {ext_q, code_q});

  always_comb begin
    held_d      = held_q;
    code_d      = code_q;
    ext_d       = ext_q;
    cnt_d       = cnt_q;
    key_press_d = 1'b0;
    if (dec_make && !hit) begin
      held_d      = 1'b1;
      code_d      = byte_q;
      ext_d       = dec_ext;
      cnt_d       = cnt_q + 1'b1;
      key_press_d = 1'b1;
    end else if (dec_brk && hit) begin
      held_d = 1'b0;
    end
  end

  always_comb begin
    ascii = 8'hFF;
    if (!ext_q) begin
      case (code_q)
        8'h45: ascii = 8'h30;  8'h16: ascii = 8'h31;  8'h1E: ascii = 8'h32;  8'h26: ascii = 8'h33;
        8'h25: ascii = 8'h34;  8'h2E: ascii = 8'h35;  8'h36: ascii = 8'h36;  8'h3D: ascii = 8'h37;
        8'h3E: ascii = 8'h38;  8'h46: ascii = 8'h39;  8'h1C: ascii = 8'h41;  8'h32: ascii = 8'h42;
        8'h21: ascii = 8'h43;  8'h23: ascii = 8'h44;  8'h24: ascii = 8'h45;  8'h2B: ascii = 8'h46;
        default: ascii = 8'hFF;
      endcase
    end
  end

  always_comb begin
    seg_d        = '1;
    if (held_q) begin
      seg_d[7:0]   = hex7(code_q[3:0]);
      seg_d[15:8]  = hex7(code_q[7:4]);
      seg_d[23:16] = hex7(ascii[3:0]);
      seg_d[31:24] = hex7(ascii[7:4]);
    end
    for (int k = 0; k < CNT_DIGITS; k++) begin
      seg_d[8*(4+k) +: 8] = hex7(cnt_q[4*k +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      held_q      <= 1'b0;
      code_q      <= '0;
      ext_q       <= 1'b0;
      cnt_q       <= '0;
      key_press_q <= 1'b0;
      seg_q       <= {{CNT_DIGITS{8'hC0}}, 32'hFFFF_FFFF};
    end else begin
      held_q      <= held_d;
      code_q      <= code_d;
      ext_q       <= ext_d;
      cnt_q       <= cnt_d;
      key_press_q <= key_press_d;
      seg_q       <= seg_d;
    end
  end

  assign seg       = seg_q;
  assign key_press = key_press_q;
  assign frame_err = frame_err_q;
endmodule

// File: tb/tb_kbd_seg_ctrl.sv
// tb/tb_kbd_seg_ctrl.sv - table-driven and randomized bench for kbd_seg_ctrl
module tb_kbd_seg_ctrl;
  localparam int CNT_DIGITS  = 1;
  localparam int TIMEOUT_CYC = 300;
  localparam int SYNC_STAGES = 3;
  localparam int HALF        = 8;
  localparam int SW          = 8 * (4 + CNT_DIGITS);

  logic          clk = 1'b0, resetn = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [SW-1:0] seg;
  logic          key_press, frame_err;

  kbd_seg_ctrl #(.CNT_DIGITS(CNT_DIGITS), .TIMEOUT_CYC(TIMEOUT_CYC), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .seg(seg), .key_press(key_press), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, stop_cyc = 0;
  int kp_cnt = 0, fe_cnt = 0, kp_cyc = -1, fe_cyc = -1, chg_cyc = -1;
  logic [SW-1:0] seg_prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (key_press) begin kp_cnt++; kp_cyc = cyc; end
    if (frame_err) begin fe_cnt++; fe_cyc = cyc; end
    if (seg !== seg_prev) chg_cyc = cyc;
    seg_prev = seg;
  end

  logic [7:0] hex7_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [7:0] asc_key [16]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
  logic [7:0] asc_val [16]  = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                                8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
  logic [7:0] pool [10]     = '{8'hF0, 8'hE0, 8'h16, 8'h1C, 8'h45, 8'h26, 8'h75, 8'h2B, 8'h5A, 8'hF0};
  logic [7:0] wrap_keys [14] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h26,
                                 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};

  // Reference model: held key, pending E0/F0 prefixes, press count.
  logic       m_held, m_ext, m_pext, m_pbrk;
  logic [7:0] m_code;
  int         m_cnt;

  typedef struct {
    logic [7:0] b;
    bit         bad;
    bit         held;
    logic [7:0] code;
    logic [7:0] asc;
    int         cnt;
    bit         kp;
  } vec_t;
  vec_t tbl [17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_ascii(input logic ext, input logic [7:0] c);
    ref_ascii = 8'hFF;
    if (!ext) for (int i = 0; i < 16; i++) if (asc_key[i] == c) ref_ascii = asc_val[i];
  endfunction

  function automatic logic [SW-1:0] build_seg(input logic held, input logic [7:0] code,
                                              input logic [7:0] asc, input int cnt);
    logic [SW-1:0] s;
    s = '1;
    if (held) s[31:0] = {hex7_tab[asc[7:4]], hex7_tab[asc[3:0]], hex7_tab[code[7:4]], hex7_tab[code[3:0]]};
    for (int k = 0; k < CNT_DIGITS; k++) s[8*(4+k) +: 8] = hex7_tab[(cnt >> (4*k)) & 15];
    return s;
  endfunction

  task automatic model_reset();
    m_held = 0; m_ext = 0; m_pext = 0; m_pbrk = 0; m_code = 0; m_cnt = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, output bit press);
    logic same;
    press = 0;
    same  = m_held && (m_ext == m_pext) && (m_code == b);
    if (m_pbrk) begin
      if (same) m_held = 0;
      m_pbrk = 0; m_pext = 0;
    end else if (b == 8'hF0) begin
      m_pbrk = 1;
    end else if (b == 8'hE0 && !m_pext) begin
      m_pext = 1;
    end else begin
      if (!same) begin
        m_held = 1; m_code = b; m_ext = m_pext;
        m_cnt = (m_cnt + 1) % (1 << (4 * CNT_DIGITS));
        press = 1;
      end
      m_pext = 0;
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad);
    logic par;
    par = ~(^b) ^ bad;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] fr, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk); ps2_data = fr[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0; stop_cyc = cyc;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    @(negedge clk); ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad, output int dkp, output int dfe);
    int kp0, fe0;
    kp0 = kp_cnt; fe0 = fe_cnt;
    send_bits(mk_frame(b, bad), 11);
    repeat (12) @(negedge clk);
    dkp = kp_cnt - kp0; dfe = fe_cnt - fe0;
  endtask

  task automatic do_frame(input logic [7:0] b, input bit bad, input string tag);
    bit press;
    int dkp, dfe;
    press = 0;
    if (!bad) model_byte(b, press);
    send_frame(b, bad, dkp, dfe);
    check($sformatf("%s seg b=%h", tag, b), seg, build_seg(m_held, m_code, ref_ascii(m_ext, m_code), m_cnt));
    check($sformatf("%s key_press count b=%h", tag, b), dkp, press);
    check($sformatf("%s frame_err count b=%h", tag, b), dfe, bad);
    if (press) begin
      check($sformatf("%s key_press latency", tag), kp_cyc - stop_cyc, 4);
      check($sformatf("%s seg latency", tag), chg_cyc - stop_cyc, 5);
    end
    if (bad) check($sformatf("%s frame_err latency", tag), fe_cyc - stop_cyc, 3);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk); resetn = 1'b0;
    repeat (cycles) @(negedge clk);
    resetn = 1'b1;
    model_reset();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global time limit: got timeout expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    int dkp, dfe, fe0;
    bit press;
    tbl[0]  = '{8'h16, 0, 1, 8'h16, 8'h31, 1, 1};
    tbl[1]  = '{8'hF0, 0, 1, 8'h16, 8'h31, 1, 0};
    tbl[2]  = '{8'h16, 0, 0, 8'h00, 8'h00, 1, 0};
    tbl[3]  = '{8'h1C, 0, 1, 8'h1C, 8'h41, 2, 1};
    tbl[4]  = '{8'h1C, 0, 1, 8'h1C, 8'h41, 2, 0};
    tbl[5]  = '{8'h1C, 0, 1, 8'h1C, 8'h41, 2, 0};
    tbl[6]  = '{8'hF0, 0, 1, 8'h1C, 8'h41, 2, 0};
    tbl[7]  = '{8'h1C, 0, 0, 8'h00, 8'h00, 2, 0};
    tbl[8]  = '{8'h16, 1, 0, 8'h00, 8'h00, 2, 0};
    tbl[9]  = '{8'h16, 0, 1, 8'h16, 8'h31, 3, 1};
    tbl[10] = '{8'hE0, 0, 1, 8'h16, 8'h31, 3, 0};
    tbl[11] = '{8'h75, 0, 1, 8'h75, 8'hFF, 4, 1};
    tbl[12] = '{8'hF0, 0, 1, 8'h75, 8'hFF, 4, 0};
    tbl[13] = '{8'h16, 0, 1, 8'h75, 8'hFF, 4, 0};
    tbl[14] = '{8'hE0, 0, 1, 8'h75, 8'hFF, 4, 0};
    tbl[15] = '{8'hF0, 0, 1, 8'h75, 8'hFF, 4, 0};
    tbl[16] = '{8'h75, 0, 0, 8'h00, 8'h00, 4, 0};

    do_reset(4);
    repeat (4) @(negedge clk);
    check("reset seg", seg, {{CNT_DIGITS{8'hC0}}, 32'hFFFF_FFFF});
    check("reset key_press", key_press, 1'b0);
    check("reset frame_err", frame_err, 1'b0);

    for (int i = 0; i < 17; i++) begin
      if (!tbl[i].bad) model_byte(tbl[i].b, press);
      send_frame(tbl[i].b, tbl[i].bad, dkp, dfe);
      check($sformatf("vec%0d seg", i), seg, build_seg(tbl[i].held, tbl[i].code, tbl[i].asc, tbl[i].cnt));
      check($sformatf("vec%0d key_press", i), dkp, tbl[i].kp);
      check($sformatf("vec%0d frame_err", i), dfe, tbl[i].bad);
      if (tbl[i].bad) check($sformatf("vec%0d frame_err latency", i), fe_cyc - stop_cyc, 3);
      if (tbl[i].kp) check($sformatf("vec%0d key_press latency", i), kp_cyc - stop_cyc, 4);
      if (i == 0) check("make 16 literal seg", seg, 40'hF9_B0F9_F982);
    end

    fe0 = fe_cnt;
    send_bits(mk_frame(8'h33, 0), 5);
    repeat (TIMEOUT_CYC + 10) @(negedge clk);
    do_frame(8'h45, 0, "timeout");
    check("timeout ascii 30", seg[31:16], 16'hB0C0);
    check("timeout no frame_err", fe_cnt - fe0, 0);

    do_reset(1);
    do_frame(8'hE0, 0, "wrap");
    do_frame(8'h75, 0, "wrap");
    check("ext ascii FF", seg[31:16], 16'h8E8E);
    do_frame(8'h16, 0, "wrap");
    check("rollover count 2", seg[39:32], 8'hA4);
    do_frame(8'hF0, 0, "wrap");
    do_frame(8'h16, 0, "wrap");
    for (int i = 0; i < 14; i++) begin
      do_frame(wrap_keys[i], 0, "wrap");
      do_frame(8'hF0, 0, "wrap");
      do_frame(wrap_keys[i], 0, "wrap");
    end
    check("wrap literal seg", seg, 40'hC0_FFFF_FFFF);

    send_bits(mk_frame(8'h1C, 0), 5);
    do_reset(1);
    do_frame(8'h26, 0, "midreset");
    check("midreset literal seg", seg, 40'hF9_B0B0_A482);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        fe0 = fe_cnt;
        send_bits(mk_frame(8'($urandom), 0), $urandom_range(1, 9));
        repeat (TIMEOUT_CYC + 10) @(negedge clk);
        check("rand partial no frame_err", fe_cnt - fe0, 0);
      end
      do_frame(pool[$urandom_range(0, 9)], ($urandom_range(0, 9) == 0), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
